// File: rtl/core_mstr_switch.sv
// core_mstr_switch
//   N-master switch for the native valid/ready core bus. One of N_MSTR
//   masters (index 0 = mgmt core, 1..N_MSTR-1 = user cores) owns the
//   single core bus at any time. The select input is synchronised. The
//   switch never moves ownership while a transfer is outstanding, and it
//   holds the bus idle for QUIET_CYC cycles after every change of owner.
//
// Handshake: a transfer is offered while core_valid_o is high and retires
//   on the cycle where core_valid_o & core_ready_i. Masters hold
//   valid/addr/wdata/wstrb stable until they see their ready.
//
// Ports
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   sel_i               requested master index (may be asynchronous)
//   mstr_valid_i/addr_i/wdata_i/wstrb_i   per-master request, packed by index
//   mstr_rdata_o/ready_o/irq_o            per-master response, packed by index
//   core_valid_o/addr_o/wdata_o/wstrb_o   bus request
//   core_rdata_i/ready_i                  bus response
//   irq_i               SoC IRQ vector, routed to the owning master only
//   cur_sel_o           current owner index
//   switching_o         high while in DRAIN or QUIET
//   state_o             FSM state (0 RUN, 1 DRAIN, 2 QUIET) for debug
module core_mstr_switch #(
  parameter int N_MSTR    = 4,
  parameter int SEL_W     = 5,
  parameter int SYNC_STG  = 2,
  parameter int QUIET_CYC = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [N_MSTR-1:0]     mstr_valid_i,
  input  logic [N_MSTR*32-1:0]  mstr_addr_i,
  input  logic [N_MSTR*32-1:0]  mstr_wdata_i,
  input  logic [N_MSTR*4-1:0]   mstr_wstrb_i,
  output logic [N_MSTR*32-1:0]  mstr_rdata_o,
  output logic [N_MSTR-1:0]     mstr_ready_o,
  output logic [N_MSTR*32-1:0]  mstr_irq_o,
  output logic                  core_valid_o,
  output logic [31:0]           core_addr_o,
  output logic [31:0]           core_wdata_o,
  output logic [3:0]            core_wstrb_o,
  input  logic [31:0]           core_rdata_i,
  input  logic                  core_ready_i,
  input  logic [31:0]           irq_i,
  output logic [3:0]            cur_sel_o,
  output logic                  switching_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    QUIET = 2'd2
  } state_t;

  localparam logic [3:0] QCNT_INIT = 4'(QUIET_CYC);

  state_t           state;
  logic [3:0]       cur_q;
  logic [3:0]       qcnt;
  logic [SEL_W-1:0] sel_s;
  logic [31:0]      sel_ext;
  logic [3:0]       tgt;
  logic             inflight;

  // Select synchroniser; zero stages samples sel_i directly.
  generate
    if (SYNC_STG == 0) begin : g_nosync
      assign sel_s = sel_i;
    end else begin : g_sync
      logic [SEL_W-1:0] sync_q [SYNC_STG];
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          for (int i = 0; i < SYNC_STG; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= sel_i;
          for (int i = 1; i < SYNC_STG; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign sel_s = sync_q[SYNC_STG-1];
    end
  endgenerate

  // Range check uses every bit of sel_s, so stray upper bits fall back to mgmt.
  assign sel_ext  = 32'(sel_s);
  assign tgt      = (sel_ext < 32'(N_MSTR)) ? sel_ext[3:0] : 4'd0;
  assign inflight = core_valid_o & ~core_ready_i;

  // Datapath: the owner is connected in RUN and DRAIN, nobody in QUIET.
  always_comb begin
    core_valid_o = 1'b0;
    core_addr_o  = '0;
    core_wdata_o = '0;
    core_wstrb_o = '0;
    mstr_ready_o = '0;
    mstr_rdata_o = '0;
    mstr_irq_o   = '0;
    if (state != QUIET) begin
      for (int k = 0; k < N_MSTR; k++) begin
        if (cur_q == 4'(k)) begin
          core_valid_o              = mstr_valid_i[k];
          core_addr_o               = mstr_addr_i[32*k +: 32];
          core_wdata_o              = mstr_wdata_i[32*k +: 32];
          core_wstrb_o              = mstr_wstrb_i[4*k +: 4];
          mstr_ready_o[k]           = core_ready_i;
          mstr_rdata_o[32*k +: 32]  = core_rdata_i;
          mstr_irq_o[32*k +: 32]    = irq_i;
        end
      end
    end
  end

  // Ownership FSM.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= QUIET;
      cur_q <= 4'd0;
      qcnt  <= QCNT_INIT;
    end else begin
      case (state)
        RUN: begin
          if (tgt != cur_q) begin
            if (!inflight) begin
              cur_q <= tgt;
              qcnt  <= QCNT_INIT;
              state <= QUIET;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Request withdrawn: keep the owner. Otherwise hand over as soon as
          // nothing is outstanding (normally the retire cycle).
          if (tgt == cur_q) begin
            state <= RUN;
          end else if (!inflight) begin
            cur_q <= tgt;
            qcnt  <= QCNT_INIT;
            state <= QUIET;
          end
        end
        QUIET: begin
          qcnt <= qcnt - 4'd1;
          if (qcnt <= 4'd1) state <= RUN;
        end
        default: state <= QUIET;
      endcase
    end
  end

  assign cur_sel_o   = cur_q;
  assign switching_o = (state != RUN);
  assign state_o     = state;

endmodule

// File: tb/tb_core_mstr_switch.sv
// Directed bench for core_mstr_switch (N_MSTR=4, SEL_W=5, SYNC_STG=2,
// QUIET_CYC=2). The bench acts as the bus slave; expected read data is queued
// when a transfer is started and popped when the owning master sees ready.
module tb_core_mstr_switch;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    sel_i;
  logic [N-1:0]  mstr_valid_i;
  logic [N*32-1:0] mstr_addr_i, mstr_wdata_i;
  logic [N*4-1:0]  mstr_wstrb_i;
  logic [N*32-1:0] mstr_rdata_o, mstr_irq_o;
  logic [N-1:0]  mstr_ready_o;
  logic          core_valid_o;
  logic [31:0]   core_addr_o, core_wdata_o;
  logic [3:0]    core_wstrb_o;
  logic [31:0]   core_rdata_i;
  logic          core_ready_i;
  logic [31:0]   irq_i;
  logic [3:0]    cur_sel_o;
  logic          switching_o;
  logic [1:0]    state_o;

  localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_QUIET = 2'd2;

  int n_vec = 0;
  int n_miscmp = 0;
  logic [31:0] exp_q[$];

  core_mstr_switch #(.N_MSTR(4), .SEL_W(5), .SYNC_STG(2), .QUIET_CYC(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .sel_i(sel_i),
    .mstr_valid_i(mstr_valid_i), .mstr_addr_i(mstr_addr_i),
    .mstr_wdata_i(mstr_wdata_i), .mstr_wstrb_i(mstr_wstrb_i),
    .mstr_rdata_o(mstr_rdata_o), .mstr_ready_o(mstr_ready_o),
    .mstr_irq_o(mstr_irq_o), .core_valid_o(core_valid_o),
    .core_addr_o(core_addr_o), .core_wdata_o(core_wdata_o),
    .core_wstrb_o(core_wstrb_o), .core_rdata_i(core_rdata_i),
    .core_ready_i(core_ready_i), .irq_i(irq_i), .cur_sel_o(cur_sel_o),
    .switching_o(switching_o), .state_o(state_o)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Comparison point
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miscmp++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic drive_m(input int k, input logic v, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    mstr_valid_i[k]          = v;
    mstr_addr_i[32*k +: 32]  = addr;
    mstr_wdata_i[32*k +: 32] = wdata;
    mstr_wstrb_i[4*k +: 4]   = wstrb;
  endtask

  task automatic start(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] rdata);
    drive_m(k, 1'b1, addr, wdata, wstrb);
    exp_q.push_back(rdata);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Bounded wait for master k to own an active bus, then check the request.
  task automatic wait_grant(input int k, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      if (core_valid_o && cur_sel_o == 4'(k)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("grant", 128'(got), 128'(1));
    chk("bus_addr", 128'(core_addr_o), 128'(addr));
    chk("bus_wdata", 128'(core_wdata_o), 128'(wdata));
    chk("bus_wstrb", 128'(core_wstrb_o), 128'(wstrb));
  endtask

  // Slave answers; the owning master must see ready and its read data.
  task automatic finish(input int k, input logic [31:0] rdata);
    logic [31:0]  e;
    logic [127:0] exp_rd;
    core_ready_i = 1'b1;
    core_rdata_i = rdata;
    #1;
    chk("mstr_ready", 128'(mstr_ready_o), 128'(1 << k));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    exp_rd = 128'(e) << (32 * k);
    chk("mstr_rdata", mstr_rdata_o, exp_rd);
    @(negedge clk);
    mstr_valid_i[k] = 1'b0;
    core_ready_i    = 1'b0;
    core_rdata_i    = '0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; sel_i = '0; mstr_valid_i = '0; mstr_addr_i = '0;
    mstr_wdata_i = '0; mstr_wstrb_i = '0; core_rdata_i = '0;
    core_ready_i = 1'b0; irq_i = 32'hCAFE_0001;

    // Reset: master 0 already requesting; everything must stay gated.
    start(0, 32'h0000_1000, 32'h0, 4'h0, 32'hDEAD_BEEF);
    repeat (3) step();
    chk("rst_valid", 128'(core_valid_o), 128'(0));
    chk("rst_ready", 128'(mstr_ready_o), 128'(0));
    chk("rst_irq", mstr_irq_o, 128'(0));
    chk("rst_cur", 128'(cur_sel_o), 128'(0));
    chk("rst_switching", 128'(switching_o), 128'(1));
    chk("rst_state", 128'(state_o), 128'(S_QUIET));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("quiet1_valid", 128'(core_valid_o), 128'(0));
    step();
    chk("run_state", 128'(state_o), 128'(S_RUN));
    chk("irq0", mstr_irq_o, 128'(irq_i));
    wait_grant(0, 32'h0000_1000, 32'h0, 4'h0);
    finish(0, 32'hDEAD_BEEF);

    // Idle switch 0 -> 2: owner changes on the third edge, bus quiet for two.
    sel_i = 5'd2;
    irq_i = 32'h1357_2468;
    start(2, 32'h0000_2200, 32'hA5A5_0202, 4'h3, 32'h0);
    step();
    chk("sw2_cur_e1", 128'(cur_sel_o), 128'(0));
    step();
    chk("sw2_cur_e2", 128'(cur_sel_o), 128'(0));
    chk("sw2_sw_e2", 128'(switching_o), 128'(0));
    step();
    chk("sw2_cur_e3", 128'(cur_sel_o), 128'(2));
    chk("sw2_sw_e3", 128'(switching_o), 128'(1));
    chk("sw2_valid_e3", 128'(core_valid_o), 128'(0));
    step();
    chk("sw2_sw_e4", 128'(switching_o), 128'(1));
    chk("sw2_valid_e4", 128'(core_valid_o), 128'(0));
    step();
    chk("sw2_sw_e5", 128'(switching_o), 128'(0));
    chk("sw2_valid_e5", 128'(core_valid_o), 128'(1));
    chk("sw2_irq", mstr_irq_o, {32'h0, 32'h1357_2468, 64'h0});
    wait_grant(2, 32'h0000_2200, 32'hA5A5_0202, 4'h3);
    finish(2, 32'h0);

    // Back to master 0, then request master 1 during a stalled write.
    sel_i = 5'd0;
    start(0, 32'h2000_0000, 32'h1234_5678, 4'hF, 32'h0BAD_F00D);
    wait_grant(0, 32'h2000_0000, 32'h1234_5678, 4'hF);
    sel_i = 5'd1;
    drive_m(1, 1'b1, 32'h0000_3000, 32'h0, 4'h0);
    exp_q.push_back(32'h7777_0001);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("drain_cur", 128'(cur_sel_o), 128'(0));
      chk("drain_addr", 128'(core_addr_o), 128'(32'h2000_0000));
    end
    chk("drain_state", 128'(state_o), 128'(S_DRAIN));
    chk("drain_sw", 128'(switching_o), 128'(1));
    chk("drain_ready", 128'(mstr_ready_o), 128'(0));
    finish(0, 32'h0BAD_F00D);
    chk("retire_cur", 128'(cur_sel_o), 128'(1));
    chk("retire_state", 128'(state_o), 128'(S_QUIET));
    chk("retire_valid", 128'(core_valid_o), 128'(0));
    step();
    chk("m1_quiet_valid", 128'(core_valid_o), 128'(0));
    step();
    chk("m1_run_valid", 128'(core_valid_o), 128'(1));
    wait_grant(1, 32'h0000_3000, 32'h0, 4'h0);
    finish(1, 32'h7777_0001);

    // Out-of-range select falls back to mgmt; user master stays blocked.
    sel_i = 5'd7;
    start(0, 32'h0000_4000, 32'h0, 4'h0, 32'h4444_0000);
    wait_grant(0, 32'h0000_4000, 32'h0, 4'h0);
    drive_m(1, 1'b1, 32'h0000_4100, 32'h0, 4'h0);
    finish(0, 32'h4444_0000);
    mstr_valid_i[1] = 1'b0;
    repeat (3) step();
    chk("sel7_cur", 128'(cur_sel_o), 128'(0));
    chk("sel7_state", 128'(state_o), 128'(S_RUN));

    // Select pulses to 3 and back while master 0 is stalled: no switch.
    sel_i = 5'd0;
    start(0, 32'h0000_5000, 32'h5555_AAAA, 4'h5, 32'h0000_5555);
    wait_grant(0, 32'h0000_5000, 32'h5555_AAAA, 4'h5);
    sel_i = 5'd3;
    step(); step();
    sel_i = 5'd0;
    step(); step();
    chk("toggle_state_drain", 128'(state_o), 128'(S_DRAIN));
    chk("toggle_cur_drain", 128'(cur_sel_o), 128'(0));
    step(); step(); step();
    chk("toggle_state_run", 128'(state_o), 128'(S_RUN));
    chk("toggle_sw", 128'(switching_o), 128'(0));
    chk("toggle_valid", 128'(core_valid_o), 128'(1));
    finish(0, 32'h0000_5555);
    chk("toggle_cur_end", 128'(cur_sel_o), 128'(0));
    chk("toggle_state_end", 128'(state_o), 128'(S_RUN));

    // Asynchronous reset while master 1 is in flight.
    sel_i = 5'd1;
    start(1, 32'h0000_6000, 32'h0, 4'h0, 32'h6666_6666);
    wait_grant(1, 32'h0000_6000, 32'h0, 4'h0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(core_valid_o), 128'(0));
    chk("arst_cur", 128'(cur_sel_o), 128'(0));
    chk("arst_state", 128'(state_o), 128'(S_QUIET));
    void'(exp_q.pop_front());
    mstr_valid_i[1] = 1'b0;
    sel_i = 5'd0;
    @(negedge clk);
    rst_n = 1'b1;
    start(0, 32'h0000_7000, 32'h0, 4'h0, 32'h0707_0707);
    step();
    chk("arst_quiet_valid", 128'(core_valid_o), 128'(0));
    step();
    chk("arst_run_valid", 128'(core_valid_o), 128'(1));
    chk("arst_run_cur", 128'(cur_sel_o), 128'(0));
    wait_grant(0, 32'h0000_7000, 32'h0, 4'h0);
    finish(0, 32'h0707_0707);

    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
